// File: rtl/spy_readout_controller.sv
// Freezes the spy buffer on request and streams its contents oldest-first over valid/ready.
// First word 2 cycles after READ entry, 1 word/cycle when m_ready is held high; stalls hold m_data/m_last.
module spy_readout_controller #(
    parameter int WIDTH     = 6,
    parameter int DATAWIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 freeze_req,
    input  logic                 spy_write_enable,
    input  logic [WIDTH-1:0]     spy_write_pointer,
    output logic                 spy_freeze,
    output logic [WIDTH-1:0]     spy_read_addr,
    output logic                 spy_read_enable,
    input  logic [DATAWIDTH-1:0] spy_read_data,
    output logic [DATAWIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH:0]       snap_count
);
    localparam logic [WIDTH:0] SIZE = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, SETTLE, READ, DRAIN} state_t;

    state_t               state;
    logic [WIDTH:0]       fill;
    logic [WIDTH:0]       remaining;
    logic [WIDTH-1:0]     rd_addr;
    logic [WIDTH-1:0]     start;
    logic                 pend;
    logic                 pend_last;
    logic [DATAWIDTH-1:0] fifo_dat [2];
    logic                 fifo_last [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           fifo_cnt;
    logic [1:0]           in_flight;
    logic                 pop;
    logic                 issue;

    assign start   = spy_write_pointer - fill[WIDTH-1:0];
    assign m_valid = (fifo_cnt != 2'd0);
    assign m_data  = fifo_dat[rd_ptr];
    assign m_last  = fifo_last[rd_ptr];
    assign pop     = m_valid && m_ready;

    // A slot freed by this cycle's pop is reusable at once, which sustains 1 word/cycle.
    assign in_flight       = fifo_cnt + {1'b0, pend} - {1'b0, pop};
    assign issue           = (state == READ) && (in_flight < 2'd2);
    assign spy_read_enable = issue;
    assign spy_read_addr   = rd_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            fill <= '0;
        end else if (spy_write_enable && fill != SIZE) begin
            fill <= fill + (WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend      <= 1'b0;
            pend_last <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_dat[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            pend      <= issue;
            pend_last <= issue && (remaining == (WIDTH+1)'(1));
            if (pend) begin
                fifo_dat[wr_ptr]  <= spy_read_data;
                fifo_last[wr_ptr] <= pend_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= in_flight;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            spy_freeze <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            snap_count <= '0;
            rd_addr    <= '0;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    spy_freeze <= 1'b0;
                    busy       <= 1'b0;
                    if (freeze_req && !busy) begin
                        state      <= SETTLE;
                        spy_freeze <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Empty snapshot: busy stays up through the done cycle, then IDLE clears it.
                    snap_count <= fill;
                    rd_addr    <= start;
                    remaining  <= fill;
                    if (fill == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_addr   <= rd_addr + WIDTH'(1);
                        remaining <= remaining - (WIDTH+1)'(1);
                        if (remaining == (WIDTH+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state      <= IDLE;
                        spy_freeze <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spy_readout_controller.sv
// Randomized bench for spy_readout_controller with a spy-memory model and a queue-based reference.
module tb_spy_readout_controller;
    localparam int W    = 3;
    localparam int SIZE = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          freeze_req = 1'b0;
    logic          spy_write_enable = 1'b0;
    logic [W-1:0]  spy_write_pointer;
    logic          spy_freeze;
    logic [W-1:0]  spy_read_addr;
    logic          spy_read_enable;
    logic [63:0]   spy_read_data;
    logic [63:0]   m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [W:0]    snap_count;

    logic [63:0]   wdata = '0;
    logic [63:0]   mem [SIZE];
    logic [W-1:0]  mem_wptr;

    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    bit            rnd_ready = 1'b0;

    logic [63:0]   hist[$];
    logic [63:0]   exp_data[$];
    int            exp_addr[$];
    int            wptr_m = 0;
    int            issued = 0;
    int            accepted = 0;
    int            last_hs_cyc = 0;
    int            first_vld_cyc = -1;
    bit            prev_stall = 1'b0;
    logic [63:0]   held_data = '0;
    logic          held_last = 1'b0;

    spy_readout_controller #(.WIDTH(W), .DATAWIDTH(64)) dut (
        .clock(clock), .reset(reset), .freeze_req(freeze_req),
        .spy_write_enable(spy_write_enable), .spy_write_pointer(spy_write_pointer),
        .spy_freeze(spy_freeze), .spy_read_addr(spy_read_addr),
        .spy_read_enable(spy_read_enable), .spy_read_data(spy_read_data),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done), .snap_count(snap_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Spy memory: write at the pointer, registered 1-cycle read.
    assign spy_write_pointer = mem_wptr;
    always @(posedge clock) begin
        if (reset) begin
            mem_wptr <= '0;
        end else if (spy_write_enable) begin
            mem[mem_wptr] <= wdata;
            mem_wptr      <= mem_wptr + 3'd1;
        end
        if (spy_read_enable) spy_read_data <= mem[spy_read_addr];
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            exp_data.delete();
            exp_addr.delete();
            issued     = 0;
            accepted   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_vld", m_valid, 1);
                check("hold_dat", m_data, held_data);
                check("hold_last", m_last, held_last);
            end
            check("inflight_le2", (issued - accepted) <= 2, 1);
            if (spy_read_enable) begin
                if (exp_addr.size() > 0) check("rd_addr", spy_read_addr, exp_addr.pop_front());
                else check("extra_rd", spy_read_enable, 0);
                issued++;
            end
            if (m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_data.size() > 0) begin
                    check("m_data", m_data, exp_data[0]);
                    check("m_last", m_last, exp_data.size() == 1);
                    void'(exp_data.pop_front());
                end else begin
                    check("spurious_vld", m_valid, 0);
                end
                accepted++;
                last_hs_cyc = cyc;
            end
            if (spy_freeze) check("wr_while_frozen", spy_write_enable, 0);
            prev_stall = m_valid && !m_ready;
            held_data  = m_data;
            held_last  = m_last;
        end
    end

    task automatic model_write(input logic [63:0] d);
        hist.push_back(d);
        if (hist.size() > SIZE) void'(hist.pop_front());
        wptr_m = (wptr_m + 1) % SIZE;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        spy_write_enable = 1'b0;
        freeze_req = 1'b0;
        hist.delete();
        wptr_m = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            spy_write_enable = 1'b1;
            wdata = {$urandom, $urandom};
            model_write(wdata);
        end
        @(posedge clock);
        #1;
        spy_write_enable = 1'b0;
    endtask

    // Pulses freeze_req (optionally with a coincident write) and loads the expected stream.
    task automatic issue_freeze(input bit cow, output int n, output int f_cyc);
        @(posedge clock);
        #1;
        first_vld_cyc = -1;
        freeze_req = 1'b1;
        if (cow) begin
            spy_write_enable = 1'b1;
            wdata = {$urandom, $urandom};
            model_write(wdata);
        end
        f_cyc = cyc;
        n = hist.size();
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(hist[i]);
            exp_addr.push_back((wptr_m + SIZE - n + i) % SIZE);
        end
        @(posedge clock);
        #1;
        freeze_req = 1'b0;
        spy_write_enable = 1'b0;
    endtask

    task automatic readout(input bit rnd, input bit cow, input bit frz2);
        int n, f_cyc, done_cyc, busy_cyc;
        bit got_done;
        rnd_ready = rnd;
        issue_freeze(cow, n, f_cyc);
        busy_cyc = 0;
        got_done = 1'b0;
        done_cyc = 0;
        for (int t = 0; t < 300 && !got_done; t++) begin
            @(negedge clock);
            if (busy) busy_cyc++;
            freeze_req = frz2 && (cyc == f_cyc + 4);
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                if (n > 0) begin
                    check("frz_off_at_done", spy_freeze, 0);
                    check("busy_off_at_done", busy, 0);
                end
            end
        end
        freeze_req = 1'b0;
        check("done_seen", got_done, 1);
        check("snap_count", snap_count, n);
        if (n == 0) begin
            check("empty_done_lat", done_cyc - f_cyc, 2);
            check("empty_busy_cyc", busy_cyc, 2);
            check("empty_no_vld", first_vld_cyc, -1);
        end else begin
            check("done_after_last", done_cyc - last_hs_cyc, 1);
            check("first_vld_lat", first_vld_cyc - f_cyc, 4);
            check("busy_cyc", busy_cyc, done_cyc - f_cyc - 1);
            check("words_left", exp_data.size(), 0);
            check("addrs_left", exp_addr.size(), 0);
        end
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_freeze", spy_freeze, 0);
        rnd_ready = 1'b0;
    endtask

    initial begin
        int n, f_cyc;
        bit reached;

        do_reset();
        @(negedge clock);
        check("rst_freeze", spy_freeze, 0);
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_snap", snap_count, 0);
        check("rst_rden", spy_read_enable, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);

        readout(1'b0, 1'b0, 1'b0);      // empty buffer
        write_words(5);
        readout(1'b0, 1'b0, 1'b0);      // 5 words, no wrap
        write_words(6);
        readout(1'b0, 1'b0, 1'b0);      // 11 written: full, wrapped, start at pointer 3
        write_words(3);
        readout(1'b1, 1'b0, 1'b0);      // full buffer with random backpressure

        do_reset();
        write_words(4);
        readout(1'b1, 1'b1, 1'b1);      // coincident write + ignored second freeze

        do_reset();
        write_words(6);
        rnd_ready = 1'b0;
        issue_freeze(1'b0, n, f_cyc);
        reached = 1'b0;
        for (int t = 0; t < 100 && !reached; t++) begin
            @(posedge clock);
            if (accepted >= 3) reached = 1'b1;
        end
        check("mid_reached", reached, 1);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_freeze", spy_freeze, 0);
        check("midrst_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        reset = 1'b0;
        hist.delete();
        wptr_m = 0;
        readout(1'b0, 1'b0, 1'b0);      // fill counter cleared -> empty snapshot

        for (int r = 0; r < 5; r++) begin
            write_words($urandom_range(0, 10));
            readout(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
